// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port request arbiter in front of a shared combinational ALU
//
// Purpose:
//   Two requesters share one ALU. In IDLE, one valid request is granted. Its
//   operands and control code are registered onto the ALU inputs. After one
//   EXEC cycle, the ALU output is captured into rsp_data and returned to the
//   granted port. That port must consume the result before the next grant.
//   Request to response latency is two cycles, and at most one request is
//   accepted every three cycles.
//
// Parameters:
//   FIXED_PRIO   0 = round-robin on ties, 1 = port 0 always wins ties
//
// Ports:
//   CPU_CLK, CPU_RST             clock, asynchronous active-high reset
//   reqN_valid / reqN_ready      request handshake for port N (0 = EX stage, 1 = aux)
//   reqN_op1, reqN_op2, reqN_ctrl  request payload for port N
//   rspN_valid / rspN_ready      response handshake for port N
//   rsp_data                     shared result bus, meaningful while a rspN_valid is high
//   alu_op1, alu_op2, alu_ctrl   registered operands/control driven to the ALU
//   alu_result                   combinational ALU output

module alu_arbiter #(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_op1,
    input  logic [31:0] req0_op2,
    input  logic [3:0]  req0_ctrl,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_op1,
    input  logic [31:0] req1_op2,
    input  logic [3:0]  req1_ctrl,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_data,

    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        prio_q, prio_d;        // 1 = port 1 is favoured on the next tie
    logic        grant_q, grant_d;      // port that owns the in-flight operation
    logic [31:0] alu_op1_q, alu_op1_d;
    logic [31:0] alu_op2_q, alu_op2_d;
    logic [3:0]  alu_ctrl_q, alu_ctrl_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp0_valid_q, rsp0_valid_d;
    logic        rsp1_valid_q, rsp1_valid_d;

    logic        favour1;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        consume;

    // With fixed priority the pointer is ignored, so port 0 wins every tie.
    assign favour1 = FIXED_PRIO ? 1'b0 : prio_q;
    assign grant0  = req0_valid & (~req1_valid | ~favour1);
    assign grant1  = req1_valid & ~grant0;

    assign accept  = (state_q == S_IDLE) & (grant0 | grant1);

    // Only the granted port's ready can retire the response.
    assign consume = (state_q == S_RESP) & (grant_q ? rsp1_ready : rsp0_ready);

    // Ready is combinational from the valids. It is gated by reset so that it
    // stays low for the whole time reset is asserted.
    assign req0_ready = ~CPU_RST & (state_q == S_IDLE) & grant0;
    assign req1_ready = ~CPU_RST & (state_q == S_IDLE) & grant1;

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        grant_d      = grant_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_data_d   = rsp_data_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    alu_op1_d  = grant1 ? req1_op1  : req0_op1;
                    alu_op2_d  = grant1 ? req1_op2  : req0_op2;
                    alu_ctrl_d = grant1 ? req1_ctrl : req0_ctrl;
                    grant_d    = grant1;
                    // Favour whichever port did not just win.
                    prio_d     = grant0;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d   = alu_result;
                rsp0_valid_d = ~grant_q;
                rsp1_valid_d = grant_q;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (consume) begin
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
                state_d      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            state_q      <= S_IDLE;
            prio_q       <= 1'b0;
            grant_q      <= 1'b0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            alu_ctrl_q   <= '0;
            rsp_data_q   <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            grant_q      <= grant_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_data_q   <= rsp_data_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
        end
    end

    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign alu_ctrl   = alu_ctrl_q;
    assign rsp_data   = rsp_data_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - bench for alu_arbiter (round-robin and fixed-priority instances)

module tb_alu_arbiter;

    localparam logic [3:0] C_ADD = 4'd0, C_SUB = 4'd1, C_XOR = 4'd2, C_OR = 4'd3,
                           C_AND = 4'd4, C_SRL = 4'd5, C_SLL = 4'd6, C_SRA = 4'd7,
                           C_SLT = 4'd8, C_SLTU = 4'd9, C_LUI = 4'd10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // index [d][p]: d = 0 round-robin instance, d = 1 fixed-priority instance
    logic        rqv  [2][2];
    logic        rdy  [2][2];
    logic [31:0] rqa  [2][2];
    logic [31:0] rqb  [2][2];
    logic [3:0]  rqc  [2][2];
    logic        rspv [2][2];
    logic        rsprd[2][2];
    logic [31:0] rdata[2];
    logic [31:0] aop1 [2];
    logic [31:0] aop2 [2];
    logic [3:0]  actl [2];
    logic [31:0] ares [2];

    int nchk = 0;
    int nerr = 0;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
        case (c)
            C_ADD:  return a + b;
            C_SUB:  return a - b;
            C_XOR:  return a ^ b;
            C_OR:   return a | b;
            C_AND:  return a & b;
            C_SRL:  return a >> b[4:0];
            C_SLL:  return a << b[4:0];
            C_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            C_SLT:  return {31'd0, $signed(a) < $signed(b)};
            C_SLTU: return {31'd0, a < b};
            C_LUI:  return b;
            default: return 32'd0;
        endcase
    endfunction

    assign ares[0] = alu_f(aop1[0], aop2[0], actl[0]);
    assign ares[1] = alu_f(aop1[1], aop2[1], actl[1]);

    alu_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
        .CPU_CLK(clk), .CPU_RST(rst),
        .req0_valid(rqv[0][0]), .req0_ready(rdy[0][0]),
        .req0_op1(rqa[0][0]), .req0_op2(rqb[0][0]), .req0_ctrl(rqc[0][0]),
        .req1_valid(rqv[0][1]), .req1_ready(rdy[0][1]),
        .req1_op1(rqa[0][1]), .req1_op2(rqb[0][1]), .req1_ctrl(rqc[0][1]),
        .rsp0_valid(rspv[0][0]), .rsp0_ready(rsprd[0][0]),
        .rsp1_valid(rspv[0][1]), .rsp1_ready(rsprd[0][1]),
        .rsp_data(rdata[0]),
        .alu_op1(aop1[0]), .alu_op2(aop2[0]), .alu_ctrl(actl[0]), .alu_result(ares[0])
    );

    alu_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
        .CPU_CLK(clk), .CPU_RST(rst),
        .req0_valid(rqv[1][0]), .req0_ready(rdy[1][0]),
        .req0_op1(rqa[1][0]), .req0_op2(rqb[1][0]), .req0_ctrl(rqc[1][0]),
        .req1_valid(rqv[1][1]), .req1_ready(rdy[1][1]),
        .req1_op1(rqa[1][1]), .req1_op2(rqb[1][1]), .req1_ctrl(rqc[1][1]),
        .rsp0_valid(rspv[1][0]), .rsp0_ready(rsprd[1][0]),
        .rsp1_valid(rspv[1][1]), .rsp1_ready(rsprd[1][1]),
        .rsp_data(rdata[1]),
        .alu_op1(aop1[1]), .alu_op2(aop2[1]), .alu_ctrl(actl[1]), .alu_result(ares[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one in-flight transaction per instance ----------------
    // phase 0 = free, 1 = operation issued, 2 = result waiting for its owner
    int          m_phase[2] = '{0, 0};
    int          m_owner[2] = '{0, 0};
    int          m_last [2] = '{-1, -1};   // most recently granted port, -1 = none since reset
    logic [31:0] m_op1  [2] = '{0, 0};
    logic [31:0] m_op2  [2] = '{0, 0};
    logic [3:0]  m_ctrl [2] = '{0, 0};
    logic [31:0] m_res  [2] = '{0, 0};

    function automatic int winner(input int d);
        if (rqv[d][0] && rqv[d][1]) begin
            if (d == 1) return 0;
            return (m_last[d] == 0) ? 1 : 0;
        end
        if (rqv[d][0]) return 0;
        if (rqv[d][1]) return 1;
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_phase[d] = 0;
                m_last[d]  = -1;
                m_op1[d]   = 0;
                m_op2[d]   = 0;
                m_ctrl[d]  = 0;
            end else if (m_phase[d] == 0) begin
                int w;
                w = winner(d);
                if (w >= 0) begin
                    m_owner[d] = w;
                    m_last[d]  = w;
                    m_op1[d]   = rqa[d][w];
                    m_op2[d]   = rqb[d][w];
                    m_ctrl[d]  = rqc[d][w];
                    m_phase[d] = 1;
                end
            end else if (m_phase[d] == 1) begin
                m_res[d]   = alu_f(m_op1[d], m_op2[d], m_ctrl[d]);
                m_phase[d] = 2;
            end else if (rsprd[d][m_owner[d]]) begin
                m_phase[d] = 0;
            end
        end
    end

    int fp_rsp0 = 0;
    int fp_rsp1 = 0;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int w;
            w = winner(d);
            chk($sformatf("m_ready0_d%0d", d), rdy[d][0],
                !rst && m_phase[d] == 0 && w == 0);
            chk($sformatf("m_ready1_d%0d", d), rdy[d][1],
                !rst && m_phase[d] == 0 && w == 1);
            chk($sformatf("m_rsp0_d%0d", d), rspv[d][0], m_phase[d] == 2 && m_owner[d] == 0);
            chk($sformatf("m_rsp1_d%0d", d), rspv[d][1], m_phase[d] == 2 && m_owner[d] == 1);
            if (m_phase[d] == 2)
                chk($sformatf("m_data_d%0d", d), rdata[d], m_res[d]);
            chk($sformatf("m_op1_d%0d", d), aop1[d], m_op1[d]);
            chk($sformatf("m_op2_d%0d", d), aop2[d], m_op2[d]);
            chk($sformatf("m_ctrl_d%0d", d), actl[d], m_ctrl[d]);
        end
        if (rspv[1][0] === 1'b1) fp_rsp0++;
        if (rspv[1][1] === 1'b1) fp_rsp1++;
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] c);
        rqv[0][p] = v;
        rqa[0][p] = a;
        rqb[0][p] = b;
        rqc[0][p] = c;
    endtask

    int          rp[$];
    logic [31:0] rd[$];
    int          ep[3] = '{0, 1, 0};
    logic [31:0] ed[3] = '{32'd7, 32'd1, 32'd7};

    initial begin
        for (int p = 0; p < 2; p++) begin
            set_req(p, 1'b0, 32'd0, 32'd0, 4'd0);
            rsprd[0][p] = 1'b0;
            rsprd[1][p] = 1'b1;
        end
        // fixed-priority instance: both ports request continuously
        rqv[1][0] = 1'b1; rqa[1][0] = 32'd1; rqb[1][0] = 32'd2; rqc[1][0] = C_ADD;
        rqv[1][1] = 1'b1; rqa[1][1] = 32'd9; rqb[1][1] = 32'd4; rqc[1][1] = C_SUB;

        #1 rst = 1'b1;
        mid();
        // reset state, with the fixed-priority ports already requesting
        chk("rst_ready_fp0", rdy[1][0], 1'b0);
        chk("rst_rsp0", rspv[0][0], 1'b0);
        chk("rst_data", rdata[0], 32'd0);
        chk("rst_ctrl", actl[0], 4'd0);
        rst = 1'b0;

        // round-robin tie: grants alternate 0,1,0
        cyc();
        set_req(0, 1'b1, 32'd10, 32'd3, C_SUB);
        set_req(1, 1'b1, 32'hFFFF_FFFF, 32'd1, C_SLT);
        rsprd[0][0] = 1'b1;
        rsprd[0][1] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            mid();
            chk("t031_excl", rspv[0][0] & rspv[0][1], 1'b0);
            if (rspv[0][0] === 1'b1) begin rp.push_back(0); rd.push_back(rdata[0]); end
            if (rspv[0][1] === 1'b1) begin rp.push_back(1); rd.push_back(rdata[0]); end
            cyc();
        end
        chk("t031_count", rp.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t031_port%0d", i), (i < rp.size()) ? rp[i] : 99, ep[i]);
            chk($sformatf("t031_data%0d", i), (i < rd.size()) ? rd[i] : 32'hDEAD, ed[i]);
        end

        // single request on port 0: 5 + 7, response two cycles later
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        set_req(0, 1'b1, 32'd5, 32'd7, C_ADD);
        mid();
        chk("t030_ready_T", rdy[0][0], 1'b1);
        cyc();
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        mid();
        chk("t030_rsp_T1", rspv[0][0], 1'b0);
        cyc();
        mid();
        chk("t030_rsp_T2", rspv[0][0], 1'b1);
        chk("t030_data_T2", rdata[0], 32'd12);
        cyc();
        mid();
        chk("t030_rsp_T3", rspv[0][0], 1'b0);

        // backpressure on port 1 while port 0 waits
        cyc();
        rsprd[0][1] = 1'b0;
        set_req(1, 1'b1, 32'h8000_0000, 32'd4, C_SRA);
        set_req(0, 1'b1, 32'h0000_00F0, 32'h0000_000F, C_OR);
        mid();
        chk("t032_grant1", rdy[0][1], 1'b1);
        chk("t032_nogrant0", rdy[0][0], 1'b0);
        cyc();
        set_req(1, 1'b0, 32'd0, 32'd0, 4'd0);
        mid();
        chk("t032_exec_ready0", rdy[0][0], 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            mid();
            chk($sformatf("t032_hold_v%0d", i), rspv[0][1], 1'b1);
            chk($sformatf("t032_hold_d%0d", i), rdata[0], 32'hF800_0000);
            chk($sformatf("t032_hold_r%0d", i), rdy[0][0], 1'b0);
        end
        cyc();
        rsprd[0][1] = 1'b1;
        mid();
        chk("t032_still_valid", rspv[0][1], 1'b1);
        cyc();
        mid();
        chk("t032_cleared", rspv[0][1], 1'b0);
        chk("t032_port0_now", rdy[0][0], 1'b1);
        cyc();
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        mid();
        cyc();
        mid();
        chk("t032_port0_data", rdata[0], 32'h0000_00FF);
        cyc();
        cyc();

        // reset during EXEC aborts the operation
        set_req(0, 1'b1, 32'h0000_00FF, 32'h0000_000F, C_XOR);
        cyc();
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        #2 rst = 1'b1;
        #1;
        chk("t034_op1", aop1[0], 32'd0);
        chk("t034_op2", aop2[0], 32'd0);
        chk("t034_ctrl", actl[0], 4'd0);
        chk("t034_data", rdata[0], 32'd0);
        chk("t034_rsp0", rspv[0][0], 1'b0);
        chk("t034_fp_ready", rdy[1][0], 1'b0);
        mid();
        rst = 1'b0;
        set_req(0, 1'b1, 32'd3, 32'd4, C_ADD);
        #1;
        chk("t034_ready_after", rdy[0][0], 1'b1);
        cyc();
        set_req(0, 1'b0, 32'd0, 32'd0, 4'd0);
        mid();
        chk("t034_no_stale", rspv[0][0], 1'b0);
        cyc();
        mid();
        chk("t034_new_rsp", rspv[0][0], 1'b1);
        chk("t034_new_data", rdata[0], 32'd7);
        cyc();
        cyc();

        // fixed priority: port 0 served repeatedly, port 1 never
        chk("t033_p0_served", fp_rsp0 > 5, 1'b1);
        chk("t033_p1_never", fp_rsp1, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
